// File: rtl/matmul_ctrl_fsm_pkg.sv
// Shared types, default parameters and address helper for the matrix-multiply controller.
package matmul_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Row-major element address; callers truncate to their address width.
  function automatic int unsigned idx2addr(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_ctrl_fsm_if.sv
// Memory-side bus of the controller: read ports of A and B, write port of C.
interface matmul_ctrl_fsm_if #(
  parameter int DW = 32,
  parameter int AW = 7
) ();

  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic          c_we;

  modport master (
    output a_addr, b_addr, c_addr, c_data, c_we,
    input  a_data, b_data
  );

  modport slave (
    input  a_addr, b_addr, c_addr, c_data, c_we,
    output a_data, b_data
  );

endinterface

// File: rtl/matmul_ctrl_fsm_mac.sv
// Multiply-accumulate datapath: DW x DW product truncated to DW bits, wrapping accumulator.
module mm_mac #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_first,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] prod;

  assign prod = a * b;

  // First term of a dot product replaces the accumulator, later terms add to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr_first ? prod : acc + prod;
    end
  end

endmodule

// File: rtl/matmul_ctrl_fsm.sv
// Sequencer for C = A x B over N x N row-major matrices with one MAC datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, all outputs quiet
// S_READ  | A[i][k] and B[k][j] addresses presented to the memories
// S_MAC   | read data valid, accumulate into the dot product
// S_WRITE | C[i][j] written with the finished dot product
// S_DONE  | one-cycle completion pulse, start ignored
module matmul_ctrl_fsm
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  matmul_ctrl_fsm_if.master mem,
  output logic              busy,
  output logic              done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] i;
  logic [CW-1:0] j;
  logic [CW-1:0] k;
  logic [CW-1:0] i_n;
  logic [CW-1:0] j_n;
  logic          j_wrap;
  logic          c_we_q;
  logic [DW-1:0] acc;

  assign j_wrap = (j == LAST);
  assign j_n    = j_wrap ? '0 : j + CW'(1);
  assign i_n    = j_wrap ? i + CW'(1) : i;

  mm_mac #(.DW(DW)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (state == S_MAC),
    .clr_first (k == '0),
    .a         (mem.a_data),
    .b         (mem.b_data),
    .acc       (acc)
  );

  assign mem.c_we   = c_we_q;
  // Write data is only exposed while writing so the bus stays quiet otherwise.
  assign mem.c_data = c_we_q ? acc : '0;

  // State, index counters and registered Moore outputs, loaded with the values of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      mem.a_addr <= '0;
      mem.b_addr <= '0;
      mem.c_addr <= '0;
      c_we_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      c_we_q <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_READ;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            mem.a_addr <= '0;
            mem.b_addr <= '0;
            busy       <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_MAC;
        end
        S_MAC: begin
          if (k == LAST) begin
            state      <= S_WRITE;
            c_we_q     <= 1'b1;
            mem.c_addr <= AW'(idx2addr(32'(i), 32'(j), N));
          end else begin
            state      <= S_READ;
            k          <= k + CW'(1);
            mem.a_addr <= AW'(idx2addr(32'(i), 32'(k) + 1, N));
            mem.b_addr <= AW'(idx2addr(32'(k) + 1, 32'(j), N));
          end
        end
        S_WRITE: begin
          k <= '0;
          j <= j_n;
          i <= i_n;
          if (i == LAST && j == LAST) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            mem.a_addr <= '0;
            mem.b_addr <= '0;
            mem.c_addr <= '0;
          end else begin
            state      <= S_READ;
            mem.a_addr <= AW'(idx2addr(32'(i_n), 0, N));
            mem.b_addr <= AW'(idx2addr(0, 32'(j_n), N));
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_ctrl_fsm.md
Name: matmul_ctrl_fsm

Overview:
- Controller that multiplies two N×N matrices held in operand memories A and B and writes the product into result memory C.
- Drives the read address ports of A and B and the write port of C (Aw/in_Data/WE) directly.
- Sequencing uses a Moore FSM around a single multiply-accumulate datapath.
- Matrices are stored row-major: A[i][k] at i*N+k, B[k][j] at k*N+j, C[i][j] at i*N+j.

Parameters:
- N, 4, matrix dimension; N*N must be ≤ 2^AW (N ≤ 11 for AW=7).
- DW, 32, data word width.
- AW, 7, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin one full multiply.
- a_addr  out  AW  read address to memory A.
- a_data  in  DW  read data from memory A.
- b_addr  out  AW  read address to memory B.
- b_data  in  DW  read data from memory B.
- c_addr  out  AW  write address to memory C.
- c_data  out  DW  write data to memory C.
- c_we  out  1  write enable to memory C, one-cycle pulse per element.
- busy  out  1  high while in READ/MAC/WRITE.
- done  out  1  one-cycle pulse when the last element has been written.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - Counters i, j, k and the accumulator clear to 0.
  - All outputs are 0: addresses 0, c_data 0, c_we 0, busy 0, done 0.
  - Reset asserted mid-operation aborts immediately; a partial C image is left in memory with no further writes.
- Memory timing: A and B return read data one clock after the address is presented (synchronous read). C writes on the clock edge where c_we=1.
- States (Moore outputs):
  - IDLE: outputs idle. start=1 at a clock edge → READ, with i=j=k=0.
  - READ:
    - a_addr=i*N+k, b_addr=k*N+j; busy=1.
    - Always goes to MAC.
  - MAC:
    - a_data and b_data are valid this cycle.
    - acc <= (k==0) ? a*b : acc + a*b.
    - If k==N-1 → WRITE; else k++ and → READ.
  - WRITE:
    - c_we=1, c_addr=i*N+j, c_data=acc, busy=1.
    - k <= 0; j++; on j==N-1, j <= 0 and i++.
    - If i==N-1 and j==N-1 → DONE; else → READ.
  - DONE: done=1, busy=0. Always goes to IDLE; start is ignored in this state.
- Arithmetic:
  - Unsigned multiply keeping the low DW bits.
  - Accumulation is modulo 2^DW; overflow is silently wrapped and no flag is raised.
- Address arithmetic is done in AW bits; index counters are $clog2(N) bits wide, minimum 1.
- Latency:
  - Each element takes 2N+1 cycles.
  - The full product takes N*N*(2N+1) busy cycles; for N=4 that is 144.
  - done is high in the cycle N*N*(2N+1)+1 after the edge that sampled start (145 for N=4).
- start handling:
  - Ignored while busy or in DONE; no queueing.
  - If start is held high continuously, a new run begins at the first edge seen in IDLE, i.e. two cycles after done.
- N=1: READ, MAC, WRITE, DONE; exactly one write, to address 0.
- c_we is never asserted outside WRITE; no duplicate writes to the same address within a run.

Decomposition:
- Package matmul_pkg:
  - state enumeration (IDLE, READ, MAC, WRITE, DONE);
  - default N, DW, AW;
  - function idx2addr(row, col, N).
- One sub-module, mm_mac:
  - inputs clk, rst, en, clr_first, a, b;
  - output acc (DW bits, wrap-around);
  - holds the accumulator register and the DW×DW→DW product.
- The FSM, the counters and the address generation remain in matmul_ctrl_fsm.

Test Plan:
- Identity times B: A=I, B[k][j]=k*4+j+1 (N=4), start pulse.
  - C[a] = a+1 for a = 0..15.
  - Exactly 16 c_we pulses with c_addr 0,1,…,15 in order.
  - done pulse 145 cycles after the start edge; busy low when done=1.
- All-twos: A and B filled with 2 → every C word = 16.
- Wrap-around: A and B filled with 0xFFFFFFFF → each product has low word 1, so every C word = 4. Then A and B filled with 0x00010000 → every C word = 0.
- start held high for 400 cycles:
  - second run begins exactly 2 cycles after the first done;
  - start during busy causes no restart;
  - results are identical in both runs.
- Reset mid-operation: drop rst during the 3rd WRITE cycle.
  - c_we=0, busy=0 and state IDLE immediately, with no clock needed.
  - Only C[0] and C[1] are written.
  - A fresh start then completes normally.
- N=1 build (A=[7], B=[6]): C[0]=42; done 4 cycles after the start edge.
